// File: rtl/mac_acc_pkg.sv
// Shared types and constants for the MAC job sequencer: FSM states,
// register map and register bit positions.
package mac_acc_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_CLEAR   = 3'd1,
    SEQ_STREAM  = 3'd2,
    SEQ_DRAIN   = 3'd3,
    SEQ_CAPTURE = 3'd4,
    SEQ_DONE    = 3'd5
  } seq_state_t;

  localparam int VEC_LEN_MAX_DEF = 96;
  localparam int CNT_W_DEF       = 7;
  localparam int DATA_LAT_DEF    = 1;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LEN    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_DONE_CLR = 2;
  localparam int CTRL_ABORT    = 3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_LEN_ERR = 2;
  localparam int STAT_ACC_LSB = 8;

endpackage

// File: rtl/mac_valid_pipe.sv
// Valid-token delay line matching the buffer read latency; a token
// issued with a pop emerges when its data reaches the multiplier.
module mac_valid_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic issue,
  output logic arrive
);

  logic [DEPTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      stage <= '0;
    end else begin
      stage[0] <= issue;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign arrive = stage[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// Software-started job sequencer for the single-MAC datapath: register
// interface, pop/accumulate/capture control and done interrupt.
//
// state   | meaning
// IDLE    | waiting for start, LEN checked on start
// CLEAR   | one-cycle accumulator clear, counters zeroed
// STREAM  | popping operand pairs until LEN pops issued
// DRAIN   | waiting for in-flight tokens to accumulate
// CAPTURE | one-cycle result register load
// DONE    | job finished, irq raised if enabled
module mac_sequencer
  import mac_acc_pkg::*;
#(
  parameter int VEC_LEN_MAX = VEC_LEN_MAX_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DATA_LAT    = DATA_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cfg_address,
  input  logic        cfg_write,
  input  logic [31:0] cfg_writedata,
  input  logic        cfg_read,
  output logic [31:0] cfg_readdata,
  input  logic        weight_empty,
  input  logic        image_empty,
  output logic        weight_pop,
  output logic        image_pop,
  output logic        mac_clear,
  output logic        mac_acc_en,
  output logic        result_capture,
  output logic        irq
);

  localparam logic [CNT_W-1:0] LEN_LIMIT = CNT_W'(VEC_LEN_MAX);

  seq_state_t       state;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] issue_count;
  logic [CNT_W-1:0] acc_count;
  logic             irq_en;
  logic             len_err;

  logic             ctrl_wr;
  logic             start;
  logic             done_clr;
  logic             abort;
  logic             busy;
  logic             done;
  logic             len_ok;
  logic             pop;
  logic             arrive;
  logic             flush;
  logic [31:0]      status_word;
  logic [31:0]      ctrl_word;
  logic             unused_ok;

  assign ctrl_wr  = cfg_write && (cfg_address == REG_CTRL);
  // abort in the same write suppresses start
  assign abort    = ctrl_wr && cfg_writedata[CTRL_ABORT];
  assign start    = ctrl_wr && cfg_writedata[CTRL_START] && !cfg_writedata[CTRL_ABORT];
  assign done_clr = ctrl_wr && cfg_writedata[CTRL_DONE_CLR];

  assign busy   = (state != SEQ_IDLE) && (state != SEQ_DONE);
  assign done   = (state == SEQ_DONE);
  assign len_ok = (len_reg != '0) && (len_reg <= LEN_LIMIT);
  assign pop    = (state == SEQ_STREAM) && !weight_empty && !image_empty
                  && (issue_count < len_reg);
  assign flush  = abort && busy;

  mac_valid_pipe #(
    .DEPTH (DATA_LAT)
  ) u_valid_pipe (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .issue  (pop),
    .arrive (arrive)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEQ_IDLE;
      len_reg     <= '0;
      issue_count <= '0;
      acc_count   <= '0;
      irq_en      <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= cfg_writedata[CTRL_IRQ_EN];
      if (cfg_write && (cfg_address == REG_LEN) && !busy) begin
        len_reg <= cfg_writedata[CNT_W-1:0];
      end
      if (pop) issue_count <= issue_count + 1'b1;
      if (arrive) acc_count <= acc_count + 1'b1;

      case (state)
        SEQ_IDLE: begin
          if (start) begin
            if (len_ok) begin
              len_err <= 1'b0;
              state   <= SEQ_CLEAR;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        SEQ_CLEAR: begin
          issue_count <= '0;
          acc_count   <= '0;
          state       <= SEQ_STREAM;
        end
        SEQ_STREAM: begin
          if (pop && (issue_count + 1'b1 == len_reg)) state <= SEQ_DRAIN;
        end
        SEQ_DRAIN: begin
          if (acc_count == len_reg) state <= SEQ_CAPTURE;
        end
        SEQ_CAPTURE: state <= SEQ_DONE;
        SEQ_DONE: begin
          if (done_clr) state <= SEQ_IDLE;
          if (start) begin
            if (len_ok) begin
              len_err <= 1'b0;
              state   <= SEQ_CLEAR;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        default: state <= SEQ_IDLE;
      endcase

      if (flush) state <= SEQ_IDLE;
    end
  end

  always_comb begin
    status_word                  = '0;
    status_word[STAT_BUSY]       = busy;
    status_word[STAT_DONE]       = done;
    status_word[STAT_LEN_ERR]    = len_err;
    status_word[STAT_ACC_LSB+:8] = 8'(acc_count);
  end

  always_comb begin
    ctrl_word              = '0;
    ctrl_word[CTRL_IRQ_EN] = irq_en;
  end

  always_ff @(posedge clk) begin
    if (reset || !cfg_read) begin
      cfg_readdata <= '0;
    end else begin
      case (cfg_address)
        REG_CTRL:   cfg_readdata <= ctrl_word;
        REG_LEN:    cfg_readdata <= 32'(len_reg);
        REG_STATUS: cfg_readdata <= status_word;
        default:    cfg_readdata <= '0;
      endcase
    end
  end

  assign weight_pop     = pop;
  assign image_pop      = pop;
  assign mac_clear      = (state == SEQ_CLEAR);
  assign result_capture = (state == SEQ_CAPTURE);
  assign mac_acc_en     = arrive;
  assign irq            = done && irq_en;

  assign unused_ok = ^{cfg_writedata[31:CNT_W], cfg_writedata[7:4]};

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a simple occupancy model of the
// weight/image buffers and event counters on the datapath controls.
module tb_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cfg_address;
  logic        cfg_write;
  logic [31:0] cfg_writedata;
  logic        cfg_read;
  logic [31:0] cfg_readdata;
  logic        weight_empty;
  logic        image_empty;
  logic        weight_pop;
  logic        image_pop;
  logic        mac_clear;
  logic        mac_acc_en;
  logic        result_capture;
  logic        irq;

  int checks = 0;
  int errors = 0;

  int w_lvl = 0, i_lvl = 0, w_add = 0, i_add = 0;
  int n_pop = 0, n_ipop = 0, n_acc = 0, n_clr = 0, n_cap = 0;

  mac_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_address    (cfg_address),
    .cfg_write      (cfg_write),
    .cfg_writedata  (cfg_writedata),
    .cfg_read       (cfg_read),
    .cfg_readdata   (cfg_readdata),
    .weight_empty   (weight_empty),
    .image_empty    (image_empty),
    .weight_pop     (weight_pop),
    .image_pop      (image_pop),
    .mac_clear      (mac_clear),
    .mac_acc_en     (mac_acc_en),
    .result_capture (result_capture),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  assign weight_empty = (w_lvl <= 0);
  assign image_empty  = (i_lvl <= 0);

  always @(posedge clk) begin
    w_lvl <= w_lvl + w_add - (weight_pop ? 1 : 0);
    i_lvl <= i_lvl + i_add - (image_pop ? 1 : 0);
    if (weight_pop)     n_pop  <= n_pop + 1;
    if (image_pop)      n_ipop <= n_ipop + 1;
    if (mac_acc_en)     n_acc  <= n_acc + 1;
    if (mac_clear)      n_clr  <= n_clr + 1;
    if (result_capture) n_cap  <= n_cap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_address = a; cfg_writedata = d; cfg_write = 1'b1;
    @(negedge clk);
    cfg_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    cfg_address = a; cfg_read = 1'b1;
    @(negedge clk);
    cfg_read = 1'b0;
    d = cfg_readdata;
  endtask

  task automatic push(input int w, input int i);
    @(negedge clk);
    w_add = w; i_add = i;
    @(negedge clk);
    w_add = 0; i_add = 0;
  endtask

  task automatic wait_irq(input int max_cycles);
    for (int k = 0; k < max_cycles && !irq; k++) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rdata;
    logic [4:0]  exp1 [9];
    int b_pop, b_ipop, b_acc, b_clr, b_cap;

    exp1 = '{5'b10000, 5'b01100, 5'b01110, 5'b01110, 5'b01110,
             5'b00010, 5'b00000, 5'b00001, 5'b00000};

    reset = 1'b1; cfg_address = 2'd0; cfg_write = 1'b0;
    cfg_writedata = '0; cfg_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {26'd0, mac_clear, weight_pop, image_pop, mac_acc_en, result_capture, irq}, 32'd0);
    reset = 1'b0;
    rd(2'd2, rdata);
    chk("reset_status", rdata, 32'h0);

    // Job 1: LEN=4, buffers preloaded, cycle-by-cycle control trace
    wr(2'd0, 32'h2);
    wr(2'd1, 32'd4);
    rd(2'd1, rdata);
    chk("len_readback", rdata, 32'd4);
    push(4, 4);
    wr(2'd0, 32'h3);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("job1_cycle%0d", c),
          {27'd0, mac_clear, weight_pop, image_pop, mac_acc_en, result_capture}, {27'd0, exp1[c]});
    end
    chk("job1_irq", {31'd0, irq}, 32'd1);
    rd(2'd2, rdata);
    chk("job1_status", rdata, 32'h0402);
    rd(2'd3, rdata);
    chk("reserved_read", rdata, 32'h0);

    // Job 2: LEN=3 with the image buffer running dry after one pop
    wr(2'd0, 32'h6);
    chk("doneclr_irq", {31'd0, irq}, 32'd0);
    rd(2'd2, rdata);
    chk("doneclr_status", rdata, 32'h0400);
    wr(2'd1, 32'd3);
    push(3, 1);
    b_pop = n_pop; b_acc = n_acc; b_cap = n_cap; b_clr = n_clr; b_ipop = n_ipop;
    wr(2'd0, 32'h3);
    repeat (6) @(negedge clk);
    chk("stall_pops", n_pop - b_pop, 32'd1);
    chk("stall_pop_low", {31'd0, weight_pop}, 32'd0);
    push(0, 2);
    wait_irq(40);
    chk("job2_irq", {31'd0, irq}, 32'd1);
    chk("job2_pops", n_pop - b_pop, 32'd3);
    chk("job2_image_pops", n_ipop - b_ipop, 32'd3);
    chk("job2_acc", n_acc - b_acc, 32'd3);
    chk("job2_capture", n_cap - b_cap, 32'd1);
    chk("job2_clear", n_clr - b_clr, 32'd1);
    rd(2'd2, rdata);
    chk("job2_status", rdata, 32'h0302);

    // Illegal lengths: 0 and 97
    wr(2'd0, 32'h6);
    push(5, 5);
    b_pop = n_pop; b_clr = n_clr;
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h3);
    repeat (3) @(negedge clk);
    rd(2'd2, rdata);
    chk("len0_status", rdata, 32'h0304);
    wr(2'd1, 32'd97);
    wr(2'd0, 32'h3);
    repeat (3) @(negedge clk);
    rd(2'd2, rdata);
    chk("len97_status", rdata, 32'h0304);
    chk("badlen_pops", n_pop - b_pop, 32'd0);
    chk("badlen_clear", n_clr - b_clr, 32'd0);

    // LEN=96 aborted after 10 pops (start bit in the same write is ignored)
    wr(2'd1, 32'd96);
    push(91, 91);
    b_pop = n_pop; b_cap = n_cap;
    wr(2'd0, 32'h3);
    for (int k = 0; k < 200 && (n_pop - b_pop) < 10; k++) @(negedge clk);
    cfg_address = 2'd0; cfg_writedata = 32'hB; cfg_write = 1'b1;
    @(negedge clk);
    cfg_write = 1'b0;
    chk("abort_pops_total", n_pop - b_pop, 32'd11);
    chk("abort_outputs", {27'd0, mac_clear, weight_pop, mac_acc_en, result_capture, irq}, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_capture", n_cap - b_cap, 32'd0);
    chk("abort_stays_idle", {31'd0, weight_pop}, 32'd0);
    rd(2'd2, rdata);
    chk("abort_status", rdata, 32'h0A00);

    // Restart from DONE with LEN=2
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h3);
    wait_irq(40);
    chk("job4_irq", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'd2);
    b_cap = n_cap; b_clr = n_clr; b_acc = n_acc;
    wr(2'd0, 32'h3);
    chk("restart_clear", {31'd0, mac_clear}, 32'd1);
    chk("restart_irq_low", {31'd0, irq}, 32'd0);
    wait_irq(40);
    chk("job5_irq", {31'd0, irq}, 32'd1);
    rd(2'd2, rdata);
    chk("job5_status", rdata, 32'h0202);
    chk("job5_capture", n_cap - b_cap, 32'd1);
    chk("job5_clear", n_clr - b_clr, 32'd1);
    chk("job5_acc", n_acc - b_acc, 32'd2);

    // Reset in the middle of a stream
    wr(2'd0, 32'h6);
    wr(2'd1, 32'd50);
    b_pop = n_pop;
    wr(2'd0, 32'h3);
    for (int k = 0; k < 50 && (n_pop - b_pop) < 3; k++) @(negedge clk);
    chk("pre_reset_popping", {31'd0, weight_pop}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", {26'd0, mac_clear, weight_pop, image_pop, mac_acc_en, result_capture, irq}, 32'd0);
    chk("midreset_readdata", cfg_readdata, 32'h0);
    reset = 1'b0;
    b_cap = n_cap; b_pop = n_pop;
    rd(2'd2, rdata);
    chk("midreset_status", rdata, 32'h0);
    repeat (5) @(negedge clk);
    chk("midreset_no_capture", n_cap - b_cap, 32'd0);
    chk("midreset_no_pops", n_pop - b_pop, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
